// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder.
// The source side drives operands and out_ready; the adder drives everything else.
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead group per stage,
// with the group carry crossing a register into the next stage.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_cla_adder_if.slave bus
);
    localparam int N = WIDTH / GROUP;

    if (GROUP < 1 || GROUP > 8 || WIDTH < GROUP || (WIDTH % GROUP) != 0) begin : g_bad_params
        $error("pipelined_cla_adder: WIDTH must be a nonzero multiple of GROUP, GROUP in 1..8");
    end

    // One enable for the whole pipe: bubbles are kept, so a stall freezes every stage.
    logic w_en;
    assign w_en         = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = w_en;

    // Flattened lookahead: each carry is a sum of products of g/p terms, no ripple chain.
    function automatic logic [GROUP:0] cla_carries(
        input logic [GROUP-1:0] g,
        input logic [GROUP-1:0] p,
        input logic             c0
    );
        logic [GROUP:0] c;
        logic           term;
        c[0] = c0;
        for (int i = 0; i < GROUP; i++) begin
            c[i+1] = c0;
            for (int j = 0; j <= i; j++) c[i+1] &= p[j];
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) term &= p[m];
                c[i+1] |= term;
            end
        end
        return c;
    endfunction

    for (genvar k = 0; k < N; k++) begin : g_stage
        localparam int RW_IN = WIDTH - k * GROUP;

        logic [RW_IN-1:0]       w_a_in;
        logic [RW_IN-1:0]       w_b_in;
        logic                   w_c_in;
        logic                   w_v_in;
        logic [GROUP-1:0]       w_g;
        logic [GROUP-1:0]       w_p;
        logic [GROUP:0]         w_carry;
        logic [GROUP-1:0]       w_gsum;
        logic [(k+1)*GROUP-1:0] w_s_next;

        logic                   r_v;
        logic                   r_c;
        logic [(k+1)*GROUP-1:0] r_s;

        assign w_g     = w_a_in[GROUP-1:0] & w_b_in[GROUP-1:0];
        assign w_p     = w_a_in[GROUP-1:0] ^ w_b_in[GROUP-1:0];
        assign w_carry = cla_carries(w_g, w_p, w_c_in);
        assign w_gsum  = w_p ^ w_carry[GROUP-1:0];

        if (k == 0) begin : g_src
            // Subtraction is A + ~B + 1, so the borrow-in inverts into the carry-in.
            assign w_a_in   = bus.a;
            assign w_b_in   = bus.b ^ {WIDTH{bus.sub}};
            assign w_c_in   = bus.cin ^ bus.sub;
            assign w_v_in   = bus.in_valid && bus.in_ready;
            assign w_s_next = w_gsum;
        end else begin : g_link
            assign w_a_in   = g_stage[k-1].g_op.r_a;
            assign w_b_in   = g_stage[k-1].g_op.r_b;
            assign w_c_in   = g_stage[k-1].r_c;
            assign w_v_in   = g_stage[k-1].r_v;
            assign w_s_next = {w_gsum, g_stage[k-1].r_s};
        end

        // NOTE: sequential state uses non-blocking assignments so every stage samples
        // its predecessor's pre-edge value; data registers are cleared too so a reset
        // leaves no stale operand or result anywhere in the pipe.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else if (w_en) begin
                r_v <= w_v_in;
                r_c <= w_carry[GROUP];
                r_s <= w_s_next;
            end
        end

        if (k < N - 1) begin : g_op
            logic [RW_IN-GROUP-1:0] r_a;
            logic [RW_IN-GROUP-1:0] r_b;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_en) begin
                    r_a <= w_a_in[RW_IN-1:GROUP];
                    r_b <= w_b_in[RW_IN-1:GROUP];
                end
            end
        end

        if (k == N - 1) begin : g_out
            // Overflow: carry into the MSB differs from the carry out of it.
            logic r_ovf;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_ovf <= 1'b0;
                else if (w_en)
                    r_ovf <= w_carry[GROUP] ^ w_carry[GROUP-1];
            end
        end
    end

    assign bus.out_valid = g_stage[N-1].r_v;
    assign bus.sum       = g_stage[N-1].r_s;
    assign bus.cout      = g_stage[N-1].r_c;
    assign bus.ovf       = g_stage[N-1].g_out.r_ovf;
endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; successor to the fixed 4-bit combinational CLA.
- Operand width is split into GROUP-bit lookahead groups, with one register stage per group, so the carry crosses a register between groups.
- Valid/ready handshake on input and output; one operation per cycle sustained throughput.
- Used as the datapath adder wherever WIDTH > 4 or timing rules out a single-cycle ripple across groups.

Parameters:
WIDTH, 16, operand and sum width in bits; must be a multiple of GROUP (elaboration error otherwise)
GROUP, 4, lookahead group width in bits, 1..8; pipeline depth N = WIDTH/GROUP

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand set valid
in_ready  output  1  block can accept operands this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0: A+B+cin; 1: A-B-cin
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result, modulo 2^WIDTH
cout  output  1  carry out of MSB (sub: 1 = no borrow)
ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset: asserting rst_n low asynchronously clears every stage valid bit and all pipeline data registers. out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 once rst_n is high.
- Operand conditioning: b_eff = sub ? ~b : b; c0 = cin ^ sub. Subtract with cin=1 gives A-B-1.
- Stage k (1..N):
  - Computes group k-1 with full generate/propagate lookahead, using the carry registered by stage k-1 (stage 1 uses c0).
  - Registers the partial sum bits, the group carry-out, and the not-yet-used operand bits.
- Global advance enable: en = !out_valid | out_ready. in_ready = en, combinational.
- When en=1, all stages shift one place. Stage 1 loads in_valid & in_ready along with its data. When en=0, every stage holds.
- Bubbles are not collapsed: a stall freezes the whole pipe, including empty stages.
- Latency: operands accepted at edge E; the result is presented with out_valid=1 after edge E+N-1, i.e. N cycles. N=1 degenerates to a registered single-group CLA.
- A result transfers when out_valid & out_ready. Ordering is strictly FIFO.
- While out_valid=1 and out_ready=0, sum/cout/ovf remain stable.
- Flags:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Simultaneous output transfer and input acceptance in one cycle is legal and loses nothing.
- in_valid with in_ready=0 is ignored. The source must hold its operands until the handshake completes.
- Reset mid-operation: all in-flight operations are discarded. No result from before reset may appear after rst_n deasserts.
- sub and cin are sampled with the operands and carried per operation. Mixing add and sub back-to-back is legal.

Test Plan (WIDTH=16, GROUP=4, N=4 unless stated):
- Add 0xFFFF+0x0001, cin=0, out_ready=1 -> 4 cycles later: sum=0x0000, cout=1, ovf=0.
- Add 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1.
- Sub 0x0005-0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0. Sub 0x0007-0x0005 -> sum=0x0002, cout=1. Sub 0x8000-0x0001 -> sum=0x7FFF, ovf=1.
- Stream 8 back-to-back ops (a=i, b=0x0100·i) with out_ready low for 3 cycles mid-stream:
  - in_ready=0 exactly while stalled;
  - held output stable;
  - all 8 results delivered in order;
  - no duplicates or drops.
- Three ops in flight, rst_n pulsed low mid-cycle -> out_valid=0 immediately (asynchronous). After release, no stale result appears, and the next op returns correctly after 4 cycles.
- WIDTH=4, GROUP=4 instance (N=1): all 256 a/b pairs × cin × sub, streamed back-to-back -> every result matches a reference model of {cout,sum} = a + b_eff + c0, with ovf checked.
